// File: rtl/regbank_scb.sv
// regbank_scb: parametrised register bank with bypass, busy scoreboard and stream dump engine
module regbank_scb #(
    parameter int DW = 16,
    parameter int NREG = 8,
    parameter int AW = $clog2(NREG),
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    output logic [DW-1:0] rdData1,
    output logic [DW-1:0] rdData2,
    output logic          rdBusy1,
    output logic          rdBusy2,
    input  logic          write,
    input  logic [AW-1:0] dr,
    input  logic [DW-1:0] wrData,
    input  logic          issue,
    input  logic [AW-1:0] issueDr,
    input  logic          dumpStart,
    input  logic          dumpReady,
    output logic          dumpValid,
    output logic [AW-1:0] dumpIdx,
    output logic [DW-1:0] dumpData,
    output logic          dumpDone
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic [DW-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic wr_ok, iss_ok, z1, z2, fwd1, fwd2;
    assign wr_ok = write && !(ZERO_REG != 0 && dr == '0);
    assign iss_ok = issue && !(ZERO_REG != 0 && issueDr == '0);
    assign z1 = ZERO_REG != 0 && sr1 == '0;
    assign z2 = ZERO_REG != 0 && sr2 == '0;
    assign fwd1 = BYPASS != 0 && wr_ok && dr == sr1;
    assign fwd2 = BYPASS != 0 && wr_ok && dr == sr2;
    assign rdData1 = z1 ? '0 : fwd1 ? wrData : regs[sr1];
    assign rdData2 = z2 ? '0 : fwd2 ? wrData : regs[sr2];
    assign rdBusy1 = !z1 && !fwd1 && busy[sr1];
    assign rdBusy2 = !z2 && !fwd2 && busy[sr2];
    // dump shows committed contents, so a write lands on the beat the cycle after
    assign dumpData = dumpValid ? regs[dumpIdx] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[dr] <= wrData;
                busy[dr] <= 1'b0;
            end
            if (iss_ok) busy[issueDr] <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dumpValid <= 1'b0;
            dumpIdx <= '0;
            dumpDone <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dumpStart) begin
                    state <= SCAN;
                    dumpValid <= 1'b1;
                    dumpIdx <= '0;
                end
                SCAN: if (dumpReady) begin
                    if (dumpIdx == AW'(NREG - 1)) begin
                        state <= DONE;
                        dumpValid <= 1'b0;
                        dumpDone <= 1'b1;
                    end else begin
                        dumpIdx <= dumpIdx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dumpDone <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regbank_scb.sv
// tb_regbank_scb: directed checks of regbank_scb, bypassed (u_dut) and non-bypassed (u_nb) builds
module tb_regbank_scb;
    logic clk, reset, write, issue, dumpStart, dumpReady;
    logic [2:0] sr1, sr2, dr, issueDr;
    logic [15:0] wrData;
    logic [15:0] rdData1, rdData2, dumpData;
    logic rdBusy1, rdBusy2, dumpValid, dumpDone;
    logic [2:0] dumpIdx;
    logic [15:0] nb_rd1, nb_rd2, nb_dd;
    logic nb_b1, nb_b2, nb_dv, nb_done;
    logic [2:0] nb_di;
    int n = 0, errs = 0;

    regbank_scb u_dut (
        .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
        .rdBusy1(rdBusy1), .rdBusy2(rdBusy2), .write(write), .dr(dr), .wrData(wrData),
        .issue(issue), .issueDr(issueDr), .dumpStart(dumpStart), .dumpReady(dumpReady),
        .dumpValid(dumpValid), .dumpIdx(dumpIdx), .dumpData(dumpData), .dumpDone(dumpDone)
    );
    regbank_scb #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2), .rdData1(nb_rd1), .rdData2(nb_rd2),
        .rdBusy1(nb_b1), .rdBusy2(nb_b2), .write(write), .dr(dr), .wrData(wrData),
        .issue(issue), .issueDr(issueDr), .dumpStart(dumpStart), .dumpReady(dumpReady),
        .dumpValid(nb_dv), .dumpIdx(nb_di), .dumpData(nb_dd), .dumpDone(nb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b, after;
        reset = 0; write = 0; issue = 0; dumpStart = 0; dumpReady = 0;
        sr1 = 3; sr2 = 7; dr = 0; issueDr = 0; wrData = 0;
        #12;
        chk("rst_rd1", rdData1, 0);
        chk("rst_rd2", rdData2, 0);
        chk("rst_busy", {rdBusy1, rdBusy2}, 0);
        chk("rst_dv", dumpValid, 0);
        chk("rst_idx", dumpIdx, 0);
        chk("rst_dd", dumpData, 0);
        chk("rst_done", dumpDone, 0);
        tick; reset = 1;
        // R5 write, then attempted R0 write
        write = 1; dr = 5; wrData = 16'hBEEF; tick;
        dr = 0; wrData = 16'h1234; tick;
        write = 0; sr1 = 5; sr2 = 0; #1;
        chk("r5", rdData1, 16'hBEEF);
        chk("r0", rdData2, 0);
        chk("r0_busy", rdBusy2, 0);
        chk("nb_r0", nb_rd2, 0);
        // same-cycle bypass
        write = 1; dr = 2; wrData = 16'hA5A5; sr1 = 2; #1;
        chk("byp_data", rdData1, 16'hA5A5);
        chk("nobyp_data", nb_rd1, 0);
        tick; write = 0; #1;
        chk("r2_after", rdData1, 16'hA5A5);
        chk("nb_r2_after", nb_rd1, 16'hA5A5);
        // scoreboard
        issue = 1; issueDr = 4; tick;
        issue = 0; sr1 = 4; sr2 = 4; #1;
        chk("busy4_p1", rdBusy1, 1);
        chk("busy4_p2", rdBusy2, 1);
        write = 1; dr = 4; wrData = 16'h0042; #1;
        chk("busy4_byp", rdBusy1, 0);
        chk("data4_byp", rdData2, 16'h0042);
        chk("nb_busy4", nb_b1, 1);
        chk("nb_data4", nb_rd1, 0);
        tick; write = 0; #1;
        chk("busy4_after", rdBusy1, 0);
        chk("data4_after", rdData1, 16'h0042);
        chk("nb_busy4_after", nb_b2, 0);
        issue = 1; issueDr = 6; write = 1; dr = 6; wrData = 16'h0666; tick;
        issue = 0; write = 0; sr1 = 6; #1;
        chk("r6_data", rdData1, 16'h0666);
        chk("r6_busy", rdBusy1, 1);
        issue = 1; issueDr = 0; tick;
        issue = 0; sr2 = 0; #1;
        chk("r0_never_busy", rdBusy2, 0);
        // preload Rk = 0x1110+k (R0 stays zero)
        write = 1;
        for (int k = 0; k < 8; k++) begin
            dr = 3'(k); wrData = 16'h1110 + 16'(k); tick;
        end
        write = 0;
        dumpStart = 1; tick; dumpStart = 0;
        b = 0; after = 0;
        for (int c = 0; c < 24; c++) begin
            dumpReady = (c % 2) == 0;
            dumpStart = (c == 5 || c == 15);
            #1;
            chk("dump_valid", dumpValid, b < 8);
            if (b < 8) begin
                chk("dump_idx", dumpIdx, b);
                chk("dump_data", dumpData, b == 0 ? 0 : 16'h1110 + b);
            end
            chk("dump_done", dumpDone, b == 8 && after == 0);
            if (b == 8) after++;
            if (b < 8 && dumpReady) b++;
            tick;
        end
        dumpStart = 0;
        chk("dump_beats", b, 8);
        // reset in the middle of a dump
        dumpStart = 1; tick; dumpStart = 0; dumpReady = 1;
        tick; tick; tick;
        chk("mid_idx", dumpIdx, 3);
        chk("mid_data", dumpData, 16'h1113);
        #2 reset = 0; #1;
        chk("abort_valid", dumpValid, 0);
        chk("abort_idx", dumpIdx, 0);
        sr1 = 5; sr2 = 6; #1;
        chk("abort_r5", rdData1, 0);
        chk("abort_r6", rdData2, 0);
        chk("abort_busy6", rdBusy2, 0);
        tick;
        chk("abort_done", dumpDone, 0);
        reset = 1; #1;
        chk("post_done", dumpDone, 0);
        chk("post_valid", dumpValid, 0);
        tick;
        chk("post_done2", dumpDone, 0);
        dumpStart = 1; tick; dumpStart = 0; dumpReady = 0; #1;
        chk("restart_valid", dumpValid, 1);
        chk("restart_idx", dumpIdx, 0);
        tick;
        chk("restart_hold", dumpIdx, 0);
        dumpReady = 1; tick; #1;
        chk("restart_idx1", dumpIdx, 1);
        chk("restart_data1", dumpData, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
